// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM states, opcode legality.
package alu_arbiter_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

  function automatic logic op_illegal(input logic [2:0] op);
    return !(op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT});
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: and/or/add/sub/signed-slt; unsupported opcodes yield zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 3
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation in flight.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt_id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, err_q;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             gnt_id;
  logic             accept;

  // Pointer-preferred port wins if valid, otherwise the other one.
  assign gnt_id = ptr_q ? req1_valid : !req0_valid;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((req0_valid || req1_valid) && !reset) begin
          req0_ready = !gnt_id;
          req1_ready = gnt_id;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        ptr_d   = !gnt_id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      gnt_id_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        gnt_id_q <= gnt_id;
        a_q      <= gnt_id ? req1_a  : req0_a;
        b_q      <= gnt_id ? req1_b  : req0_b;
        op_q     <= gnt_id ? req1_op : req0_op;
      end
    end
  end

  alu_arbiter_alu #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (state_q == S_EXEC) begin
      result_q <= alu_result;
      zero_q   <= alu_zero;
      err_q    <= op_illegal(op_q);
    end
  end

  // Gated by reset so an op interrupted in RESP never reports.
  assign resp0_valid = (state_q == S_RESP) && !gnt_id_q && !reset;
  assign resp1_valid = (state_q == S_RESP) && gnt_id_q && !reset;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: timeline model checked every cycle plus directed literals.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp_result;
  logic        resp_zero, resp_err, busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  alu_arbiter #(.WIDTH(32), .OP_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .req1_ready  (req1_ready),
    .resp0_valid (resp0_valid),
    .resp1_valid (resp1_valid),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Timeline model: accept at cycle N -> response at N+2, next accept no earlier than N+3.
  bit          m_ptr = 1'b0, m_pend = 1'b0, m_id = 1'b0;
  int          m_free = 0, m_acc_cyc = 0, m_resp_cyc = 0;
  logic [31:0] m_res = '0, h_res = '0;
  bit          m_zero = 1'b0, m_err = 1'b0, h_zero = 1'b0, h_err = 1'b0;

  initial forever begin
    bit acc, g, due;
    @(negedge clk);
    acc = !reset && (cyc >= m_free) && (req0_valid || req1_valid);
    g   = m_ptr ? req1_valid : !req0_valid;
    due = m_pend && (cyc == m_resp_cyc);
    if (due) begin
      h_res  = m_res;
      h_zero = m_zero;
      h_err  = m_err;
    end
    check("ready0", {31'd0, req0_ready}, {31'd0, acc && !g});
    check("ready1", {31'd0, req1_ready}, {31'd0, acc && g});
    check("resp0", {31'd0, resp0_valid}, {31'd0, due && !reset && !m_id});
    check("resp1", {31'd0, resp1_valid}, {31'd0, due && !reset && m_id});
    check("busy", {31'd0, busy}, {31'd0, m_pend && (cyc > m_acc_cyc)});
    check("result", resp_result, h_res);
    check("zero", {31'd0, resp_zero}, {31'd0, h_zero});
    check("err", {31'd0, resp_err}, {31'd0, h_err});
    if (reset) begin
      m_pend = 1'b0;
      m_ptr  = 1'b0;
      m_free = cyc + 1;
      h_res  = '0;
      h_zero = 1'b0;
      h_err  = 1'b0;
    end else begin
      if (due) begin
        m_ptr  = !m_id;
        m_pend = 1'b0;
      end
      if (acc) begin
        m_pend     = 1'b1;
        m_id       = g;
        m_acc_cyc  = cyc;
        m_resp_cyc = cyc + 2;
        m_free     = cyc + 3;
        m_res      = g ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
        m_zero     = (m_res == 32'd0);
        m_err      = g ? !(req1_op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111})
                       : !(req0_op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    if (p) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // which: 0 ready0, 1 ready1, 2 resp0, 3 resp1; bounded wait sampled on negedge.
  task automatic wait_sig(input int which, input string nm, output int at);
    bit seen = 1'b0;
    logic s;
    at = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       s = req0_ready;
        1:       s = req1_ready;
        2:       s = resp0_valid;
        default: s = resp1_valid;
      endcase
      if (s === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check({nm, " seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic issue(input bit p, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] er, input bit ez, input bit ee,
                       input string nm);
    int n, r;
    drive(p, 1'b1, a, b, op);
    wait_sig(p ? 1 : 0, {nm, " ready"}, n);
    step();
    drive(p, 1'b0, '0, '0, '0);
    wait_sig(p ? 3 : 2, {nm, " resp"}, r);
    check({nm, " latency"}, r - n, 32'd2);
    check({nm, " result"}, resp_result, er);
    check({nm, " zero"}, {31'd0, resp_zero}, {31'd0, ez});
    check({nm, " err"}, {31'd0, resp_err}, {31'd0, ee});
  endtask

  initial begin
    int n0, n1, r, pulses;
    // 1: reset 2 cycles, then idle
    step();
    step();
    reset = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (req0_ready || req1_ready || resp0_valid || resp1_valid || busy) pulses++;
    end
    check("t1 pulses", pulses, 0);
    check("t1 result", resp_result, 32'd0);
    // 2: simple add
    step();
    issue(1'b0, 32'h0000FFFF, 32'h1, 3'b010, 32'h00010000, 1'b0, 1'b0, "t2");
    // 3: contested from reset
    step();
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h0000FFFF, 32'h0000FFFF, 3'b110);
    drive(1'b1, 1'b1, 32'h0000FFFF, 32'h1, 3'b110);
    step();
    reset = 1'b0;
    wait_sig(0, "t3 ready0", n0);
    step();
    drive(1'b0, 1'b0, '0, '0, '0);
    wait_sig(2, "t3 resp0", r);
    check("t3 result0", resp_result, 32'd0);
    check("t3 zero0", {31'd0, resp_zero}, 32'd1);
    wait_sig(1, "t3 ready1", n1);
    check("t3 spacing", n1 - n0, 32'd3);
    step();
    drive(1'b1, 1'b0, '0, '0, '0);
    wait_sig(3, "t3 resp1", r);
    check("t3 result1", resp_result, 32'h0000FFFE);
    check("t3 zero1", {31'd0, resp_zero}, 32'd0);
    // 4: back-to-back on port 1, slt then and
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'h1, 3'b111);
    wait_sig(1, "t4 ready a", n0);
    step();
    drive(1'b1, 1'b1, 32'h0000FFFF, 32'hFFFF0000, 3'b000);
    wait_sig(3, "t4 resp a", r);
    check("t4 slt", resp_result, 32'd1);
    wait_sig(1, "t4 ready b", n1);
    check("t4 spacing", n1 - n0, 32'd3);
    step();
    drive(1'b1, 1'b0, '0, '0, '0);
    wait_sig(3, "t4 resp b", r);
    check("t4 and", resp_result, 32'd0);
    check("t4 zero", {31'd0, resp_zero}, 32'd1);
    // 5: illegal opcode, then legal
    issue(1'b0, 32'h12345678, 32'h9, 3'b011, 32'd0, 1'b1, 1'b1, "t5 illegal");
    issue(1'b0, 32'h1, 32'h2, 3'b010, 32'd3, 1'b0, 1'b0, "t5 legal");
    // 6: pointer now favours port 1; reset during EXEC must restore port 0 priority
    drive(1'b0, 1'b1, 32'h5, 32'h6, 3'b010);
    wait_sig(0, "t6 ready", n0);
    step();
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    step();
    reset = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid) pulses++;
    end
    check("t6 no resp", pulses, 0);
    step();
    drive(1'b0, 1'b1, 32'h7, 32'h1, 3'b110);
    drive(1'b1, 1'b1, 32'h7, 32'h2, 3'b110);
    wait_sig(0, "t6 contested", n0);
    check("t6 not port1", {31'd0, req1_ready}, 32'd0);
    step();
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    repeat (6) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
